// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of the Johnson ring counter: monitor states,
// default phase-index width and the phase successor rule.
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int PHASE_W       = $clog2(2 * DEFAULT_WIDTH);

    function automatic logic [31:0] next_phase(input logic [31:0] phase,
                                               input logic [31:0] seq_len);
        return (phase + 32'd1) % seq_len;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: flags legality and returns the phase as
// both a binary index and a one-hot vector.
module johnson_decode #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   code_i,
    output logic               legal_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [2*WIDTH-1:0] onehot_o
);

    logic [WIDTH-1:0] pattern;

    // Build the reference code for every phase and match against the input.
    always_comb begin
        legal_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        pattern  = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                pattern[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
            end
            if (code_i == pattern) begin
                legal_o     = 1'b1;
                idx_o       = IDX_W'(k);
                onehot_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter, decodes its phase, checks step order, declares
// lock, counts revolutions and latches a sticky fault on illegal codes.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_en,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              q_in,
    output logic                          phase_valid,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          lock,
    output logic                          fault,
    output logic                          step_err,
    output logic [CNT_W-1:0]              wrap_count
);

    localparam int IDX_W  = $clog2(2 * WIDTH);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    logic               dec_legal;
    logic [IDX_W-1:0]   dec_idx;
    logic [2*WIDTH-1:0] dec_onehot;
    logic               is_succ;

    state_t             state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]   wrap_q, wrap_d;
    logic               valid_q, valid_d;
    logic [2*WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               step_err_q, step_err_d;

    johnson_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .code_i   (q_in),
        .legal_o  (dec_legal),
        .idx_o    (dec_idx),
        .onehot_o (dec_onehot)
    );

    // The last captured phase doubles as the predecessor; UNLOCKED means none.
    assign is_succ = (32'(dec_idx) == next_phase(32'(idx_q), 32'(2 * WIDTH)));

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        wrap_d     = wrap_q;
        valid_d    = valid_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        step_err_d = 1'b0;
        if (clear) begin
            state_d = UNLOCKED;
            good_d  = '0;
            wrap_d  = '0;
        end else if (sample_en && state_q != FAULT) begin
            if (!dec_legal) begin
                state_d = FAULT;
            end else begin
                valid_d  = 1'b1;
                onehot_d = dec_onehot;
                idx_d    = dec_idx;
                case (state_q)
                    UNLOCKED: begin
                        state_d = LOCKING;
                        good_d  = '0;
                    end
                    LOCKING: begin
                        if (is_succ) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_d == GOOD_W'(LOCK_COUNT)) state_d = LOCKED;
                        end else begin
                            good_d     = '0;
                            step_err_d = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (is_succ) begin
                            if (dec_idx == '0) wrap_d = wrap_q + CNT_W'(1);
                        end else begin
                            state_d    = LOCKING;
                            good_d     = '0;
                            step_err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            good_q     <= '0;
            wrap_q     <= '0;
            valid_q    <= 1'b0;
            onehot_q   <= '0;
            idx_q      <= '0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            wrap_q     <= wrap_d;
            valid_q    <= valid_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            step_err_q <= step_err_d;
        end
    end

    assign phase_valid  = valid_q;
    assign phase_onehot = onehot_q;
    assign phase_idx    = idx_q;
    assign lock         = (state_q == LOCKED);
    assign fault        = (state_q == FAULT);
    assign step_err     = step_err_q;
    assign wrap_count   = wrap_q;

endmodule
